password_match_stage: RTL



---
 rtl/password_match_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/password_match_stage.sv
`default_nettype none
// ============================================================================
//  Module   : password_match_stage
//  Brief    : Converts base-36 candidates to ASCII in two pipeline stages and
//             compares each one against a loaded target; sticky found/done.
//  Revision : 1.0 - initial release
// ============================================================================
module password_match_stage #(
   parameter int NUM_CHARS = 4,
   parameter int DIGIT_W   = 6,
   parameter int CNT_W     = 24
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CHARS*8-1:0]        target,
   input  logic                          target_load,
   input  logic                          cand_valid,
   output logic                          cand_ready,
   input  logic [NUM_CHARS*DIGIT_W-1:0]  cand_digits,
   input  logic                          cand_last,
   output logic                          found,
   output logic [NUM_CHARS*8-1:0]        found_word,
   output logic                          done,
   output logic                          bad_digit,
   output logic [CNT_W-1:0]              checked_count
);

   localparam int               c_word_w  = NUM_CHARS * 8;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN       = 2'd1,
      S_FOUND     = 2'd2,
      S_EXHAUSTED = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [c_word_w-1:0]  r_target;
   logic                 r_s1_valid;
   logic [c_word_w-1:0]  r_s1_word;
   logic                 r_s1_last;
   logic                 r_s1_bad;
   logic [c_word_w-1:0]  r_found_word;
   logic                 r_bad_digit;
   logic [CNT_W-1:0]     r_count;

   logic [c_word_w-1:0]  w_cand_word;
   logic [NUM_CHARS-1:0] w_char_bad;
   logic                 w_accept;
   logic                 w_eval;
   logic                 w_match;

   function automatic logic [7:0] digit_to_ascii(input logic [DIGIT_W-1:0] d);
      int di;
      di = int'(d);
      if (di < 26)      return 8'(32'h61 + di);
      else if (di < 36) return 8'(32'h30 + di - 26);
      else              return 8'h00;
   endfunction

   for (genvar i = 0; i < NUM_CHARS; i++) begin : g_char
      assign w_cand_word[(NUM_CHARS-1-i)*8 +: 8] =
         digit_to_ascii(cand_digits[(NUM_CHARS-1-i)*DIGIT_W +: DIGIT_W]);
      assign w_char_bad[i] = int'(cand_digits[(NUM_CHARS-1-i)*DIGIT_W +: DIGIT_W]) > 35;
   end

   assign cand_ready = (r_state == S_RUN) && !target_load;
   assign w_accept   = cand_valid && cand_ready;

   // A stage-1 entry left over after leaving RUN is never evaluated, which
   // drops the one in-flight candidate that follows a match.
   assign w_eval  = r_s1_valid && (r_state == S_RUN) && !target_load;
   assign w_match = w_eval && !r_s1_bad && (r_s1_word == r_target);

   always_comb begin
      w_state_next = r_state;
      if (target_load)
         w_state_next = S_RUN;
      else if (w_match)
         w_state_next = S_FOUND;
      else if (w_eval && r_s1_last)
         w_state_next = S_EXHAUSTED;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_target     <= '0;
         r_s1_valid   <= 1'b0;
         r_s1_word    <= '0;
         r_s1_last    <= 1'b0;
         r_s1_bad     <= 1'b0;
         r_found_word <= '0;
         r_bad_digit  <= 1'b0;
         r_count      <= '0;
      end else begin
         r_state    <= w_state_next;
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_word <= w_cand_word;
            r_s1_last <= cand_last;
            r_s1_bad  <= |w_char_bad;
         end
         if (target_load) begin
            r_target     <= target;
            r_found_word <= '0;
            r_bad_digit  <= 1'b0;
            r_count      <= '0;
         end else if (w_eval) begin
            if (r_count != c_cnt_max)
               r_count <= r_count + 1'b1;
            if (r_s1_bad)
               r_bad_digit <= 1'b1;
            if (w_match)
               r_found_word <= r_s1_word;
         end
      end
   end

   assign found         = (r_state == S_FOUND);
   assign done          = (r_state == S_FOUND) || (r_state == S_EXHAUSTED);
   assign found_word    = r_found_word;
   assign bad_digit     = r_bad_digit;
   assign checked_count = r_count;

endmodule
`default_nettype wire
